dmem_arb: RTL and testbench

Two-port arbiter and sequencer in front of the word-organised data memory. It accepts load/store requests from the multicycle CPU datapath (port 0) and the debug/DMA agent (port 1). One request is granted at a time, and the block produces the memory's word address, byte enables, load-extension op codes and write strobe. It returns read data and status to the winning port on a one-cycle response pulse.

---
 rtl/dmem_arb_pkg.sv | 71 +++++++
 rtl/dmem_arb_if.sv | 55 +++++
 rtl/dmem_arb_rr.sv | 59 +++++
 rtl/dmem_arb.sv | 159 +++++++++++++++
 tb/tb_dmem_arb.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types, constants and decode helpers for the
// two-port data-memory arbiter (dmem_arb).
//   size_t     - access size encoding carried on req_size
//   state_t    - sequencer states (IDLE -> ISSUE -> RESP)
//   BE_*       - byte-enable patterns driven on mem_be
//   OP_*       - {mem_op, mem_op2} load-extension pairs
//   mem_req_t  - one selected request as seen by the sequencer
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10,
        RSVD = 2'b11
    } size_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        RESP  = 2'b10
    } state_t;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    // {op, op2}
    localparam logic [3:0] OP_NORM  = 4'b0100;
    localparam logic [3:0] OP_SBYTE = 4'b0010;
    localparam logic [3:0] OP_SHALF = 4'b0011;

    // 'signed' is a reserved word, hence is_signed.
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        size_t       size;
        logic        is_signed;
        logic [31:0] wdata;
    } mem_req_t;

    function automatic logic [3:0] be_of(input size_t sz);
        logic [3:0] be;
        case (sz)
            BYTE:    be = BE_BYTE;
            HALF:    be = BE_HALF;
            WORD:    be = BE_WORD;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Sign extension only applies to sub-word loads; stores and word
    // loads always use the plain pair.
    function automatic logic [3:0] op_of(input logic we, input size_t sz,
                                         input logic sgn);
        logic [3:0] op;
        op = OP_NORM;
        if (!we && sgn) begin
            if (sz == BYTE) op = OP_SBYTE;
            if (sz == HALF) op = OP_SHALF;
        end
        return op;
    endfunction

    // Every legal access is naturally aligned to a word boundary, so any
    // nonzero low address bits reject the request regardless of size.
    function automatic logic access_err(input size_t sz, input logic [1:0] lo);
        return (sz == RSVD) || (lo != 2'b00);
    endfunction

endpackage

// File: rtl/dmem_arb_if.sv
// dmem_arb_if: request/response and memory-side bus of dmem_arb.
//   req_*   - per-port load/store requests (index = port id)
//   resp_*  - one-cycle response to the owning port
//   mem_*   - word-organised data memory port (mem_rd is combinational)
//   state   - sequencer state, exported for observation
// Modports: slave = the arbiter, master = requesters plus memory.
//
// Handshake: a port raises req_valid[p] with stable request fields and
// holds them until it sees req_ready[p] high in the same cycle; the
// request is taken on that rising edge. req_ready never depends on
// anything but req_valid and arbitration state, and at most one bit is
// high. Responses have no back-pressure: resp_valid[p] is a single-cycle
// pulse that the port must take when it appears.
interface dmem_arb_if;
    import dmem_arb_pkg::*;

    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0]       req_we;
    logic [1:0][31:0] req_addr;
    logic [1:0][1:0]  req_size;
    logic [1:0]       req_signed;
    logic [1:0][31:0] req_wdata;

    logic [1:0]       resp_valid;
    logic [31:0]      resp_rdata;
    logic             resp_err;

    logic             mem_we;
    logic [31:0]      mem_a;
    logic [3:0]       mem_be;
    logic [1:0]       mem_op;
    logic [1:0]       mem_op2;
    logic [31:0]      mem_wd;
    logic [31:0]      mem_rd;

    state_t           state;

    modport slave (
        input  req_valid, req_we, req_addr, req_size, req_signed, req_wdata,
        input  mem_rd,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_we, mem_a, mem_be, mem_op, mem_op2, mem_wd,
        output state
    );

    modport master (
        output req_valid, req_we, req_addr, req_size, req_signed, req_wdata,
        output mem_rd,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_we, mem_a, mem_be, mem_op, mem_op2, mem_wd,
        input  state
    );

endinterface

// File: rtl/dmem_arb_rr.sv
// dmem_arb_rr: two-way grant logic for dmem_arb.
// Configuration macro: DMEM_ARB_RR_EN
//   defined   - round robin; a one-bit pointer remembers the last granted
//               port, and the other port wins a tie.
//   undefined - fixed priority, port 0 always wins; no pointer exists.
// Ports:
//   clk, reset_n - clock and asynchronous active-low reset
//   valid        - per-port request valid
//   arb_en       - grants are allowed this cycle (sequencer idle)
//   accept       - a grant is being taken on this edge
//   gnt          - one-hot (or zero) grant, combinational from valid
module dmem_arb_rr (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] valid,
    input  logic       arb_en,
    input  logic       accept,
    output logic [1:0] gnt
);

`ifdef DMEM_ARB_RR_EN
    // Reset to "port 1 went last" so port 0 wins the first tie.
    logic last_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q <= 1'b1;
        end else if (accept) begin
            last_q <= gnt[1];
        end
    end

    always_comb begin
        gnt = 2'b00;
        if (arb_en) begin
            if (valid == 2'b11) begin
                gnt = last_q ? 2'b01 : 2'b10;
            end else begin
                gnt = valid;
            end
        end
    end
`else
    logic unused_rr;
    assign unused_rr = ^{clk, reset_n, accept};

    always_comb begin
        gnt = 2'b00;
        if (arb_en) begin
            if (valid[0]) begin
                gnt = 2'b01;
            end else if (valid[1]) begin
                gnt = 2'b10;
            end
        end
    end
`endif

endmodule

// File: rtl/dmem_arb.sv
// dmem_arb: two-port arbiter and sequencer in front of the word-organised
// data memory. Port 0 is the CPU datapath, port 1 the debug/DMA agent.
// One access at a time runs IDLE (grant) -> ISSUE (memory cycle) -> RESP
// (response pulse), i.e. one access every three cycles.
// Configuration macro: DMEM_ARB_RR_EN selects round-robin arbitration in
// dmem_arb_rr; without it port 0 has fixed priority.
// Ports:
//   clk     - clock, rising edge
//   reset_n - asynchronous active-low reset
//   bus     - dmem_arb_if.slave: requests, responses, memory, state
module dmem_arb
    import dmem_arb_pkg::*;
#(
    parameter int NPORT = 2
) (
    input  logic      clk,
    input  logic      reset_n,
    dmem_arb_if.slave bus
);

    state_t           state_q;
    state_t           state_d;

    logic [NPORT-1:0] gnt;
    logic             arb_en;
    logic             accept;
    logic             win;
    mem_req_t         sel;
    logic             sel_err;

    logic             port_q;
    logic             err_q;
    logic             store_q;

    logic             mem_we_q;
    logic [31:0]      mem_a_q;
    logic [3:0]       mem_be_q;
    logic [3:0]       mem_ops_q;
    logic [31:0]      mem_wd_q;

    logic [1:0]       resp_valid_q;
    logic [31:0]      resp_rdata_q;
    logic             resp_err_q;

    // ---------------------------------------------------------------
    // Arbitration. Gating with reset_n keeps req_ready low while reset
    // is held even though the state already reads IDLE.
    // ---------------------------------------------------------------
    assign arb_en = reset_n && (state_q == IDLE);

    dmem_arb_rr u_rr (
        .clk    (clk),
        .reset_n(reset_n),
        .valid  (bus.req_valid),
        .arb_en (arb_en),
        .accept (accept),
        .gnt    (gnt)
    );

    assign accept        = |(gnt & bus.req_valid);
    assign win           = gnt[1];
    assign bus.req_ready = gnt;

    always_comb begin
        sel           = '0;
        sel.we        = bus.req_we[win];
        sel.addr      = bus.req_addr[win];
        sel.size      = size_t'(bus.req_size[win]);
        sel.is_signed = bus.req_signed[win];
        sel.wdata     = bus.req_wdata[win];
    end

    assign sel_err = access_err(sel.size, sel.addr[1:0]);

    // ---------------------------------------------------------------
    // Sequencer FSM
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = ISSUE;
            ISSUE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // Datapath. Memory-side outputs are loaded on the accepting edge so
    // they are valid for the whole ISSUE cycle straight from flops, and
    // cleared on the edge that closes ISSUE. A rejected access keeps
    // mem_we/mem_be at zero so the memory sees no write and no lanes.
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            port_q       <= 1'b0;
            err_q        <= 1'b0;
            store_q      <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_a_q      <= '0;
            mem_be_q     <= '0;
            mem_ops_q    <= '0;
            mem_wd_q     <= '0;
            resp_valid_q <= '0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            // Response fields live for exactly the RESP cycle.
            resp_valid_q <= '0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        port_q    <= win;
                        err_q     <= sel_err;
                        store_q   <= sel.we;
                        mem_we_q  <= sel.we && !sel_err;
                        mem_a_q   <= {2'b00, sel.addr[31:2]};
                        mem_be_q  <= sel_err ? 4'b0000 : be_of(sel.size);
                        mem_ops_q <= op_of(sel.we, sel.size, sel.is_signed);
                        mem_wd_q  <= sel.wdata;
                    end
                end
                ISSUE: begin
                    mem_we_q     <= 1'b0;
                    mem_a_q      <= '0;
                    mem_be_q     <= '0;
                    mem_ops_q    <= '0;
                    mem_wd_q     <= '0;
                    resp_valid_q <= port_q ? 2'b10 : 2'b01;
                    resp_rdata_q <= (err_q || store_q) ? 32'h0 : bus.mem_rd;
                    resp_err_q   <= err_q;
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_we     = mem_we_q;
    assign bus.mem_a      = mem_a_q;
    assign bus.mem_be     = mem_be_q;
    assign bus.mem_op     = mem_ops_q[3:2];
    assign bus.mem_op2    = mem_ops_q[1:0];
    assign bus.mem_wd     = mem_wd_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_dmem_arb.sv
// tb_dmem_arb: directed bench for dmem_arb with a behavioural data memory.
// Drivers push hand-computed expectations at acceptance; a negedge
// monitor checks ISSUE-cycle memory signals and each response.
`timescale 1ns/1ps
module tb_dmem_arb;
    import dmem_arb_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_arb_if bus ();

    dmem_arb #(.NPORT(2)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    // Behavioural memory: word array, lane-masked writes at the clock
    // edge, combinational read with the requested extension.
    logic [31:0] mem [256] = '{default: 32'h0};
    logic [31:0] raw;

    always_comb begin
        raw = mem[bus.mem_a[7:0]];
        case ({bus.mem_op, bus.mem_op2})
            4'b0010: bus.mem_rd = {{24{raw[7]}}, raw[7:0]};
            4'b0011: bus.mem_rd = {{16{raw[15]}}, raw[15:0]};
            default: bus.mem_rd = raw & {{8{bus.mem_be[3]}}, {8{bus.mem_be[2]}},
                                         {8{bus.mem_be[1]}}, {8{bus.mem_be[0]}}};
        endcase
    end

    always @(posedge clk) begin
        if (bus.mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.mem_be[i]) mem[bus.mem_a[7:0]][8*i +: 8] <= bus.mem_wd[8*i +: 8];
            end
        end
    end

    // Scoreboard
    int          n_vec = 0;
    int          n_miss = 0;
    logic [65:0] exp_q[$];  // {port, err, rdata, due cycle}
    logic [40:0] mem_q[$];  // {we, a, be, op/op2}
    int          gnt_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_miss++;
        $display("FAIL %s: event missing or unexpected at cycle %0d", name, cyc);
    endtask

    always @(negedge clk) begin
        logic [65:0] e;
        logic [40:0] m;
        if (reset_n) begin
            if ((bus.req_valid & bus.req_ready) != 2'b00) gnt_q.push_back(int'(bus.req_ready[1]));
            if (bus.state == ISSUE) begin
                if (mem_q.size() == 0) begin
                    fail_now("issue_unexpected");
                end else begin
                    m = mem_q.pop_front();
                    check("mem_we", 32'(bus.mem_we), 32'(m[40]));
                    check("mem_a", bus.mem_a, m[39:8]);
                    check("mem_be", 32'(bus.mem_be), 32'(m[7:4]));
                    check("mem_op", 32'({bus.mem_op, bus.mem_op2}), 32'(m[3:0]));
                end
            end
            if (bus.resp_valid != 2'b00) begin
                if (exp_q.size() == 0) begin
                    fail_now("resp_unexpected");
                end else begin
                    e = exp_q.pop_front();
                    check("resp_valid", 32'(bus.resp_valid), e[65] ? 32'd2 : 32'd1);
                    check("resp_err", 32'(bus.resp_err), 32'(e[64]));
                    check("resp_rdata", bus.resp_rdata, e[63:32]);
                    check("resp_cycle", cyc, e[31:0]);
                    check("mem_idle", bus.mem_a | bus.mem_wd | 32'({bus.mem_we, bus.mem_be, bus.mem_op, bus.mem_op2}), 32'h0);
                end
            end
        end
    end

    // Driver: present a request on port p, hold it until granted.
    task automatic issue(input int p, input logic we, input logic [31:0] addr,
                         input logic [1:0] sz, input logic sgn, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_err,
                         input logic [31:0] exp_a, input logic [3:0] exp_be,
                         input logic [3:0] exp_op);
        bit got = 0;
        bus.req_we[p]     = we;
        bus.req_addr[p]   = addr;
        bus.req_size[p]   = sz;
        bus.req_signed[p] = sgn;
        bus.req_wdata[p]  = wd;
        bus.req_valid[p]  = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.req_ready[p]) begin
                exp_q.push_back({p[0], exp_err, exp_rd, 32'(cyc + 2)});
                mem_q.push_back({we & ~exp_err, exp_a, exp_be, exp_op});
                got = 1;
                break;
            end
        end
        if (!got) fail_now("req_timeout");
        @(posedge clk);
        #1;
        bus.req_valid[p] = 1'b0;
    endtask

    logic [3:0] exp_gnt;

    initial begin
        bit got;
        bus.req_valid  = 2'b11;
        bus.req_we     = '0;
        bus.req_addr   = '0;
        bus.req_size   = '0;
        bus.req_signed = '0;
        bus.req_wdata  = '0;
`ifdef DMEM_ARB_RR_EN
        exp_gnt = 4'b1010;
`else
        exp_gnt = 4'b0000;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(bus.req_ready), 32'h0);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
        check("rst_rdata", bus.resp_rdata, 32'h0);
        check("rst_err", 32'(bus.resp_err), 32'h0);
        check("rst_state", 32'(bus.state), 32'(IDLE));
        check("rst_mem", bus.mem_a | bus.mem_wd | 32'({bus.mem_we, bus.mem_be, bus.mem_op, bus.mem_op2}), 32'h0);
        bus.req_valid = 2'b00;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Word store then load
        issue(0, 1, 32'h40, WORD, 0, 32'hDEADBEEF, 32'h0,        0, 32'h10, 4'hF, OP_NORM);
        issue(0, 0, 32'h40, WORD, 0, 32'h0,        32'hDEADBEEF, 0, 32'h10, 4'hF, OP_NORM);
        // Sub-word stores and loads
        issue(0, 1, 32'h44, BYTE, 0, 32'h00000080, 32'h0,        0, 32'h11, 4'h1, OP_NORM);
        issue(0, 1, 32'h48, HALF, 0, 32'h00008001, 32'h0,        0, 32'h12, 4'h3, OP_NORM);
        issue(0, 0, 32'h44, BYTE, 1, 32'h0,        32'hFFFFFF80, 0, 32'h11, 4'h1, OP_SBYTE);
        issue(0, 0, 32'h48, HALF, 1, 32'h0,        32'hFFFF8001, 0, 32'h12, 4'h3, OP_SHALF);
        issue(0, 0, 32'h44, BYTE, 0, 32'h0,        32'h00000080, 0, 32'h11, 4'h1, OP_NORM);
        issue(0, 0, 32'h48, HALF, 0, 32'h0,        32'h00008001, 0, 32'h12, 4'h3, OP_NORM);
        // Rejected accesses, including a misaligned store that must not land
        issue(0, 0, 32'h42, HALF, 1, 32'h0,        32'h0,        1, 32'h10, 4'h0, OP_SHALF);
        issue(0, 0, 32'h50, RSVD, 0, 32'h0,        32'h0,        1, 32'h14, 4'h0, OP_NORM);
        issue(0, 1, 32'h41, BYTE, 0, 32'h000000FF, 32'h0,        1, 32'h10, 4'h0, OP_NORM);
        issue(1, 0, 32'h40, WORD, 0, 32'h0,        32'hDEADBEEF, 0, 32'h10, 4'hF, OP_NORM);

        // Contention: both ports continuously valid
        repeat (2) @(posedge clk);
        #1;
        gnt_q.delete();
        fork
            begin
                for (int k = 0; k < 4; k++)
                    issue(0, 0, 32'h40, WORD, 0, 32'h0, 32'hDEADBEEF, 0, 32'h10, 4'hF, OP_NORM);
            end
            begin
                for (int k = 0; k < 4; k++)
                    issue(1, 0, 32'h48, HALF, 0, 32'h0, 32'h00008001, 0, 32'h12, 4'h3, OP_NORM);
            end
        join
        check("gnt_count", 32'(gnt_q.size()), 32'd8);
        for (int k = 0; k < 4 && k < gnt_q.size(); k++)
            check($sformatf("gnt_order_%0d", k), 32'(gnt_q[k]), 32'(exp_gnt[k]));

        // Reset during ISSUE of a store
        issue(1, 1, 32'h60, WORD, 0, 32'hCAFEF00D, 32'h0,        0, 32'h18, 4'hF, OP_NORM);
        issue(1, 0, 32'h60, WORD, 0, 32'h0,        32'hCAFEF00D, 0, 32'h18, 4'hF, OP_NORM);
        repeat (2) @(posedge clk);
        #1;
        bus.req_we[0]     = 1'b1;
        bus.req_addr[0]   = 32'h60;
        bus.req_size[0]   = WORD;
        bus.req_signed[0] = 1'b0;
        bus.req_wdata[0]  = 32'h12345678;
        bus.req_valid[0]  = 1'b1;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.req_ready[0]) begin
                got = 1;
                break;
            end
        end
        if (!got) fail_now("abort_req_timeout");
        @(posedge clk);
        #1;
        bus.req_valid[0] = 1'b0;
        check("abort_issue_we", 32'(bus.mem_we), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("abort_state", 32'(bus.state), 32'(IDLE));
        check("abort_mem", bus.mem_a | bus.mem_wd | 32'({bus.mem_we, bus.mem_be, bus.mem_op, bus.mem_op2}), 32'h0);
        check("abort_resp", 32'({bus.resp_valid, bus.resp_err}) | bus.resp_rdata, 32'h0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        issue(0, 0, 32'h60, WORD, 0, 32'h0, 32'hCAFEF00D, 0, 32'h18, 4'hF, OP_NORM);

        repeat (6) @(posedge clk);
        #1;
        check("resp_drained", 32'(exp_q.size()), 32'd0);
        check("issue_drained", 32'(mem_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
